id_inst_queue: RTL
==================

Name: id_inst_queue

Overview:
- Parametrised IF→ID decoupling queue; next generation of the single-entry IF/ID pipeline register.
- Buffers fetch packets {pc, inst, delay-slot flag, fetch address-error flag, interrupt tag} in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Supports whole-queue flush on exception/ERET and tags the next dequeued instruction with a pending interrupt.
- Sits between the fetch unit and the decode logic; decode sees a NOP bubble whenever the queue is empty.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- XLEN, 32, width of pc and inst fields.
- RESET_PC, 32'hbfc00000, pc value presented on the bubble output.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries and the pending interrupt (exception commit / ERET).
- int_req  in  1  level interrupt request from CP0 (Status/Cause masked).
- in_valid  in  1  fetch packet valid.
- in_ready  out  1  queue can accept a packet (= !full).
- in_pc  in  XLEN  fetch pc.
- in_inst  in  XLEN  fetched instruction word.
- in_bd  in  1  instruction is in a branch delay slot.
- in_adel  in  1  instruction fetch address error.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes the head this cycle (low = ID stall).
- out_pc  out  XLEN  head pc; RESET_PC when empty.
- out_inst  out  XLEN  head instruction; 0 (NOP) when empty.
- out_bd  out  1  head delay-slot flag; 0 when empty.
- out_adel  out  1  head address-error flag; 0 when empty.
- out_int  out  1  head carries an interrupt; 0 when empty.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, active-high): pointers = 0, count = 0, int_pending = 0. Outputs: out_valid=0, in_ready=1, out_pc=RESET_PC, out_inst=0, out_bd/out_adel/out_int=0. Reset mid-operation drops all entries immediately.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Push writes the tail entry at the clock edge; wr_ptr wraps modulo DEPTH.
- Pop advances rd_ptr modulo DEPTH.
- Latency: a packet pushed in cycle N is visible on out_* in cycle N+1 (registered storage, no bypass unless the optional feature is enabled).
- Outputs are combinational from the head entry and int_pending; no output depends on in_* (except under the optional feature).
- Count: +1 on push only, −1 on pop only, unchanged on push & pop. Full = (count==DEPTH); empty = (count==0).
- Full with pop in the same cycle: in_ready stays 0 (registered full). The push is not accepted; occupancy drops to DEPTH−1.
- Empty with out_ready=1: no pop, out_* show the bubble.
- Flush has priority over push, pop and int_req in the same cycle. Next cycle: count=0, out_valid=0, int_pending=0. A packet presented together with flush is discarded.
- Interrupt tagging:
  - int_pending next = flush ? 0 : int_req ? 1 : (pop & out_int) ? 0 : int_pending.
  - out_int = out_valid & int_pending.
  - The tag attaches only to the current head; it is never stored into entries.
- Address-error entries are queued and popped like any other; the queue never self-flushes.
- Data fields of popped or flushed entries are don't-care; the bubble values are forced on the outputs.

Optional Feature:
- Macro IDQ_BYPASS_EN.
- Defined: when the queue is empty, in_valid=1 and out_ready=1 (no flush), the input packet appears on out_* in the same cycle with out_valid=1. It is consumed without being written, so count stays 0, and the zero-latency path matches the old single-register behaviour. When the queue is empty and out_ready=0, the packet is written normally.
- Undefined: minimum latency is 1 cycle as above, and out_* never depend on in_*.

Test Plan:
- Reset then idle → out_valid=0, out_pc=32'hbfc00000, out_inst=0, in_ready=1, count=0.
- Push pc 0xbfc00000..0xbfc0000c (DEPTH=4) with out_ready=0 → count=4, in_ready=0. A fifth packet pc 0xbfc00010 is held by fetch. Then set out_ready=1 → four pops in order 0x..00, 0x..04, 0x..08, 0x..0c, then the bubble.
- Simultaneous push & pop at count=2 for 10 cycles → count stays 2; pointers wrap past DEPTH; data order preserved.
- Fill 3 entries, assert flush together with in_valid (pc 0xbfc00020) → next cycle count=0, out_valid=0. The flushed-cycle packet is absent. Pushing pc 0x80000180 afterwards is the next out_pc.
- int_req pulse for 1 cycle while the head is inst 0x00000000 with out_ready=0 → out_int=1 held for 3 stall cycles. On pop it clears; the next entry has out_int=0. Flush in the same cycle as int_req → int_pending=0.
- Push packet {in_bd=1, in_adel=1, pc=0xbfc00003} → popped with out_bd=1, out_adel=1, pc=0xbfc00003. With IDQ_BYPASS_EN, an empty queue with out_ready=1 shows the packet in the same cycle and count remains 0.

Source files
------------

// File: rtl/id_inst_queue.sv
// id_inst_queue: IF->ID decoupling FIFO with flush and interrupt tagging.
// Define IDQ_BYPASS_EN for the same-cycle path through an empty queue.
module id_inst_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'hbfc00000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    int_req,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [XLEN-1:0]         in_inst,
    input  logic                    in_bd,
    input  logic                    in_adel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_inst,
    output logic                    out_bd,
    output logic                    out_adel,
    output logic                    out_int,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [XLEN-1:0] mem_inst [DEPTH];
    logic            mem_bd   [DEPTH];
    logic            mem_adel [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          int_pending;
    logic          empty;
    logic          full;
    logic          bypass;
    logic          push;
    logic          head_pop;
    logic          pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign in_ready = !full;

`ifdef IDQ_BYPASS_EN
    assign bypass = empty & in_valid & out_ready & !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed packet is consumed straight from the inputs, never stored.
    assign push      = in_valid & in_ready & !bypass & !flush;
    assign head_pop  = !empty & out_ready & !flush;
    assign out_valid = !empty | bypass;
    assign pop       = out_valid & out_ready;
    assign out_int   = out_valid & int_pending;

    always_comb begin
        out_pc   = RESET_PC;
        out_inst = '0;
        out_bd   = 1'b0;
        out_adel = 1'b0;
        if (bypass) begin
            out_pc   = in_pc;
            out_inst = in_inst;
            out_bd   = in_bd;
            out_adel = in_adel;
        end else if (!empty) begin
            out_pc   = mem_pc[rd_ptr];
            out_inst = mem_inst[rd_ptr];
            out_bd   = mem_bd[rd_ptr];
            out_adel = mem_adel[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= in_pc;
            mem_inst[wr_ptr] <= in_inst;
            mem_bd[wr_ptr]   <= in_bd;
            mem_adel[wr_ptr] <= in_adel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (head_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !head_pop)
                count <= count + 1'b1;
            else if (!push && head_pop)
                count <= count - 1'b1;
        end
    end

    // The tag follows whichever instruction is at the head, until it leaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            int_pending <= 1'b0;
        else if (flush)
            int_pending <= 1'b0;
        else if (int_req)
            int_pending <= 1'b1;
        else if (pop && out_int)
            int_pending <= 1'b0;
    end

endmodule
